// File: rtl/filter_job_scheduler.sv
// Job scheduler for the image filter datapath.
// Validates host opcodes, clears the histogram RAM and runs one or two passes.
module filter_job_scheduler #(
    parameter int IMAGE_WIDTH       = 320,
    parameter int IMAGE_HEIGHT      = 240,
    parameter int PIXEL_COUNT_WIDTH = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT),
    parameter int HIST_BINS         = 256,
    localparam int HAW              = $clog2(HIST_BINS)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    input  logic [15:0]    cmd_data,
    output logic           cmd_ready,
    input  logic           abort,
    input  logic           pause_req,
    input  logic           pixel_strobe,
    output logic [15:0]    filter_command,
    output logic           filter_stop,
    output logic           filter_start,
    output logic           hist_clear_we,
    output logic [HAW-1:0] hist_clear_addr,
    output logic           busy,
    output logic           done,
    output logic           error
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STATS,
        ST_MAIN,
        ST_FINISH
    } state_t;

    localparam logic [15:0] OP_A010 = 16'hA010;
    localparam logic [15:0] OP_A020 = 16'hA020;
    localparam logic [15:0] OP_A030 = 16'hA030;
    localparam logic [15:0] OP_A040 = 16'hA040;
    localparam logic [15:0] OP_A050 = 16'hA050;
    localparam logic [15:0] OP_A060 = 16'hA060;

    localparam logic [PIXEL_COUNT_WIDTH-1:0] LAST_PIX =
        PIXEL_COUNT_WIDTH'(IMAGE_WIDTH*IMAGE_HEIGHT-1);
    localparam logic [HAW-1:0] LAST_BIN = HAW'(HIST_BINS-1);

    state_t                       state_q;
    logic [15:0]                  op_q;
    logic                         gap_q;
    logic [PIXEL_COUNT_WIDTH-1:0] pix_cnt_q;
    logic [PIXEL_COUNT_WIDTH-1:0] pix_cnt_d;
    logic [15:0]                  cmd_q;
    logic                         stop_q;
    logic                         start_q;
    logic                         we_q;
    logic [HAW-1:0]               addr_q;
    logic                         busy_q;
    logic                         done_q;
    logic                         error_q;

    logic in_pass;
    logic pix_accept;
    logic pass_last;
    logic op_valid;
    logic op_hist;

    assign cmd_ready       = rst && (state_q == ST_IDLE);
    assign filter_command  = cmd_q;
    assign filter_stop     = stop_q;
    assign filter_start    = start_q;
    assign hist_clear_we   = we_q;
    assign hist_clear_addr = addr_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;

    // Opcode classification and pixel accounting for the active pass.
    always_comb begin
        op_valid = 1'b0;
        op_hist  = 1'b0;
        unique case (cmd_data)
            OP_A010, OP_A020, OP_A030, OP_A060: op_valid = 1'b1;
            OP_A040, OP_A050: begin
                op_valid = 1'b1;
                op_hist  = 1'b1;
            end
            default: op_valid = 1'b0;
        endcase
        in_pass    = (state_q == ST_STATS) ||
                     ((state_q == ST_MAIN) && !gap_q);
        pix_accept = in_pass && pixel_strobe && !stop_q;
        pass_last  = pix_accept && (pix_cnt_q == LAST_PIX);
        pix_cnt_d  = pix_cnt_q;
        if (pix_accept) begin
            pix_cnt_d = pass_last ? '0 : pix_cnt_q + 1'b1;
        end
    end

    // Job sequencer with registered filter, RAM and status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            gap_q     <= 1'b0;
            pix_cnt_q <= '0;
            cmd_q     <= '0;
            stop_q    <= 1'b1;
            start_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            if (abort && (state_q != ST_IDLE)) begin
                state_q   <= ST_IDLE;
                gap_q     <= 1'b0;
                pix_cnt_q <= '0;
                cmd_q     <= '0;
                stop_q    <= 1'b1;
                we_q      <= 1'b0;
                addr_q    <= '0;
                busy_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (cmd_valid) begin
                            if (!op_valid) begin
                                error_q <= 1'b1;
                            end else if (op_hist) begin
                                op_q    <= cmd_data;
                                busy_q  <= 1'b1;
                                state_q <= ST_CLEAR;
                                we_q    <= 1'b1;
                                addr_q  <= '0;
                            end else begin
                                op_q      <= cmd_data;
                                busy_q    <= 1'b1;
                                state_q   <= ST_MAIN;
                                gap_q     <= 1'b0;
                                start_q   <= 1'b1;
                                cmd_q     <= cmd_data;
                                stop_q    <= pause_req;
                                pix_cnt_q <= '0;
                            end
                        end
                    end
                    ST_CLEAR: begin
                        addr_q <= addr_q + 1'b1;
                        if (addr_q == LAST_BIN) begin
                            we_q      <= 1'b0;
                            addr_q    <= '0;
                            state_q   <= ST_STATS;
                            start_q   <= 1'b1;
                            cmd_q     <= OP_A040;
                            stop_q    <= pause_req;
                            pix_cnt_q <= '0;
                        end
                    end
                    ST_STATS: begin
                        stop_q    <= pause_req;
                        pix_cnt_q <= pix_cnt_d;
                        if (pass_last) begin
                            cmd_q  <= '0;
                            stop_q <= 1'b1;
                            if (op_q == OP_A040) begin
                                state_q <= ST_FINISH;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ST_MAIN;
                                gap_q   <= 1'b1;
                            end
                        end
                    end
                    ST_MAIN: begin
                        if (gap_q) begin
                            gap_q     <= 1'b0;
                            start_q   <= 1'b1;
                            cmd_q     <= op_q;
                            stop_q    <= pause_req;
                            pix_cnt_q <= '0;
                        end else begin
                            stop_q    <= pause_req;
                            pix_cnt_q <= pix_cnt_d;
                            if (pass_last) begin
                                state_q <= ST_FINISH;
                                done_q  <= 1'b1;
                                cmd_q   <= '0;
                                stop_q  <= 1'b1;
                            end
                        end
                    end
                    ST_FINISH: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        cmd_q   <= '0;
                        stop_q  <= 1'b1;
                        we_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_filter_job_scheduler.sv
// Directed bench for filter_job_scheduler on an 8x8 image, 16-bin histogram.
// Expected values are hand-derived cycle by cycle.
module tb_filter_job_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [15:0] cmd_data;
    logic        cmd_ready;
    logic        abort;
    logic        pause_req;
    logic        pixel_strobe;
    logic [15:0] filter_command;
    logic        filter_stop;
    logic        filter_start;
    logic        hist_clear_we;
    logic [3:0]  hist_clear_addr;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;
    int starts = 0;
    int dones  = 0;

    always #5 clk = ~clk;

    filter_job_scheduler #(
        .IMAGE_WIDTH (8),
        .IMAGE_HEIGHT(8),
        .HIST_BINS   (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_data       (cmd_data),
        .cmd_ready      (cmd_ready),
        .abort          (abort),
        .pause_req      (pause_req),
        .pixel_strobe   (pixel_strobe),
        .filter_command (filter_command),
        .filter_stop    (filter_stop),
        .filter_start   (filter_start),
        .hist_clear_we  (hist_clear_we),
        .hist_clear_addr(hist_clear_addr),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (filter_start) starts++;
        if (done) dones++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic strobes(input int n);
        pixel_strobe = 1'b1;
        repeat (n) tick();
        pixel_strobe = 1'b0;
    endtask

    task automatic accept(input logic [15:0] op);
        cmd_valid = 1'b1;
        cmd_data  = op;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        cmd_valid = 1'b0;
        cmd_data = 16'h0;
        abort = 1'b0;
        pause_req = 1'b0;
        pixel_strobe = 1'b0;
        tick();
        tick();
        chk("rst_ready", cmd_ready, 0);
        chk("rst_stop", filter_stop, 1);
        chk("rst_cmd", filter_command, 0);
        chk("rst_start", filter_start, 0);
        chk("rst_we", hist_clear_we, 0);
        chk("rst_addr", hist_clear_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", error, 0);
        rst = 1'b1;
        tick();
        chk("idle_ready", cmd_ready, 1);

        // A030 single pass
        starts = 0;
        dones = 0;
        accept(16'hA030);
        chk("a030_start", filter_start, 1);
        chk("a030_busy", busy, 1);
        chk("a030_cmd", filter_command, 16'hA030);
        chk("a030_stop", filter_stop, 0);
        chk("a030_ready", cmd_ready, 0);
        strobes(63);
        chk("a030_cmd63", filter_command, 16'hA030);
        chk("a030_done63", done, 0);
        strobes(1);
        chk("a030_done", done, 1);
        chk("a030_fcmd", filter_command, 0);
        chk("a030_fstop", filter_stop, 1);
        chk("a030_fbusy", busy, 1);
        tick();
        chk("a030_done_off", done, 0);
        chk("a030_busy_off", busy, 0);
        chk("a030_nstart", starts, 1);
        chk("a030_ndone", dones, 1);

        // A050: clear, stats, gap, main
        starts = 0;
        dones = 0;
        accept(16'hA050);
        chk("a050_busy", busy, 1);
        chk("a050_cstop", filter_stop, 1);
        chk("a050_ccmd", filter_command, 0);
        chk("a050_cstart", filter_start, 0);
        for (int i = 0; i < 16; i++) begin
            chk("clr_we", hist_clear_we, 1);
            chk("clr_addr", hist_clear_addr, i);
            tick();
        end
        chk("stats_we", hist_clear_we, 0);
        chk("stats_start", filter_start, 1);
        chk("stats_cmd", filter_command, 16'hA040);
        strobes(63);
        chk("stats_cmd63", filter_command, 16'hA040);
        strobes(1);
        chk("gap_cmd", filter_command, 0);
        chk("gap_stop", filter_stop, 1);
        chk("gap_start", filter_start, 0);
        chk("gap_done", done, 0);
        tick();
        chk("main_start", filter_start, 1);
        chk("main_cmd", filter_command, 16'hA050);
        strobes(63);
        chk("main_done63", done, 0);
        strobes(1);
        chk("a050_done", done, 1);
        tick();
        chk("a050_busy_off", busy, 0);
        chk("a050_nstart", starts, 2);
        chk("a050_ndone", dones, 1);

        // Invalid opcode
        accept(16'hA070);
        chk("bad_err", error, 1);
        chk("bad_ready", cmd_ready, 1);
        chk("bad_busy", busy, 0);
        chk("bad_cmd", filter_command, 0);
        tick();
        chk("bad_err_off", error, 0);

        // A010 with pause and ignored strobes
        dones = 0;
        accept(16'hA010);
        chk("a010_cmd", filter_command, 16'hA010);
        strobes(10);
        pause_req = 1'b1;
        tick();
        chk("pause_stop", filter_stop, 1);
        strobes(4);
        chk("pause_stop4", filter_stop, 1);
        pause_req = 1'b0;
        tick();
        chk("resume_stop", filter_stop, 0);
        strobes(53);
        chk("a010_done53", done, 0);
        chk("a010_busy53", busy, 1);
        strobes(1);
        chk("a010_done", done, 1);
        tick();
        chk("a010_ndone", dones, 1);

        // A040 abort on final strobe
        dones = 0;
        accept(16'hA040);
        repeat (16) tick();
        chk("a040_cmd", filter_command, 16'hA040);
        strobes(63);
        pixel_strobe = 1'b1;
        abort = 1'b1;
        tick();
        pixel_strobe = 1'b0;
        abort = 1'b0;
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_cmd", filter_command, 0);
        chk("abort_stop", filter_stop, 1);
        chk("abort_ready", cmd_ready, 1);
        tick();
        chk("abort_done2", done, 0);
        chk("abort_ndone", dones, 0);

        // Reset mid-pass then fresh A020
        accept(16'hA060);
        strobes(20);
        rst = 1'b0;
        tick();
        chk("mrst_stop", filter_stop, 1);
        chk("mrst_cmd", filter_command, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ready", cmd_ready, 0);
        rst = 1'b1;
        tick();
        chk("mrst_ready1", cmd_ready, 1);
        chk("mrst_ndone", dones, 0);
        accept(16'hA020);
        chk("a020_start", filter_start, 1);
        chk("a020_cmd", filter_command, 16'hA020);
        strobes(63);
        chk("a020_done63", done, 0);
        chk("a020_busy63", busy, 1);
        strobes(1);
        chk("a020_done", done, 1);
        tick();
        chk("a020_busy_off", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/filter_job_scheduler.md
Name: filter_job_scheduler

Overview:
- Sequences the filter datapath for one full-image job per host command.
- Accepts a 16-bit filter opcode over a valid/ready handshake and validates it.
- For histogram jobs, clears the histogram RAM, then runs the required passes.
- Drives the filter's command/stop inputs and counts completed pixels to detect the end of each pass.

Parameters:
IMAGE_WIDTH, 320, image width in pixels
IMAGE_HEIGHT, 240, image height in pixels
PIXEL_COUNT_WIDTH, $clog2(IMAGE_WIDTH*IMAGE_HEIGHT), pixel counter width
HIST_BINS, 256, histogram RAM depth (2^PIXEL_WIDTH)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
cmd_valid  in  1  host command valid
cmd_data  in  16  filter opcode
cmd_ready  out  1  scheduler can accept a command
abort  in  1  cancel current job
pause_req  in  1  host request to halt the filter
pixel_strobe  in  1  filter wrote one output pixel (one-cycle pulse)
filter_command  out  16  opcode driven to filter datapath
filter_stop  out  1  halts filter datapath
filter_start  out  1  one-cycle pulse at start of each pass
hist_clear_we  out  1  histogram RAM write enable (writes 0)
hist_clear_addr  out  $clog2(HIST_BINS)  histogram RAM clear address
busy  out  1  job in progress
done  out  1  one-cycle pulse, job finished
error  out  1  one-cycle pulse, invalid opcode rejected

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE, counters 0. Outputs: filter_command=0, filter_stop=1, filter_start=0, hist_clear_we=0, hist_clear_addr=0, busy=0, done=0, error=0. cmd_ready=0 while rst=0.
- Reset mid-job discards the job and produces no done.
- States: IDLE, CLEAR, STATS, MAIN, FINISH.
- cmd_ready=1 only in IDLE with rst=1. A command is accepted when cmd_valid & cmd_ready at a clk edge.
- Valid opcodes: A010, A020, A030, A040, A050, A060.
  - Invalid opcode: error=1 the next cycle; stay IDLE; busy stays 0.
  - A040 path: CLEAR -> STATS -> FINISH.
  - A050 path: CLEAR -> STATS -> MAIN -> FINISH.
  - A010/A020/A030/A060 path: MAIN -> FINISH.
- busy=1 in every state except IDLE, starting the cycle after acceptance.
- CLEAR:
  - hist_clear_we=1 for exactly HIST_BINS consecutive cycles, with hist_clear_addr 0..HIST_BINS-1.
  - Not affected by pause_req.
  - filter_stop=1 and filter_command=0 throughout.
- STATS and MAIN (pass states):
  - filter_command=A040 in STATS; the latched opcode in MAIN.
  - filter_start=1 in the first cycle of each pass; pixel counter reset to 0 on entry.
  - filter_stop is pause_req registered: 1-cycle latency.
  - pixel_strobe increments the counter only when filter_stop=0; strobes are ignored while stopped.
  - Pass ends on an accepted strobe with counter = IMAGE_WIDTH*IMAGE_HEIGHT-1. The next state is entered on the following edge.
  - Counter wraps to 0 on pass end.
  - On STATS->MAIN, one cycle of filter_command=0, filter_stop=1 precedes MAIN's start pulse.
- FINISH: lasts one cycle; done=1, filter_command=0, filter_stop=1; then IDLE.
- abort (any non-IDLE state):
  - Next cycle: IDLE, filter_command=0, filter_stop=1, hist_clear_we=0, busy=0.
  - No done, no error.
  - abort beats a simultaneous final strobe.
  - abort in IDLE is ignored.
- done and error never assert in the same cycle.
- cmd_valid while busy is not accepted. The host holds it; acceptance occurs in the first IDLE cycle after FINISH.

Test Plan:
(Bench parameters: IMAGE_WIDTH=8, IMAGE_HEIGHT=8, HIST_BINS=16.)
- A030 accepted, 64 strobes -> filter_start 1 cycle after acceptance; filter_command=A030 during pass; done pulse 1 cycle after 64th strobe; busy low next cycle.
- A050 accepted -> 16 clear writes (addr 0..15), STATS with A040 for 64 strobes, 1 idle gap, MAIN with A050 for 64 strobes, single done; exactly two filter_start pulses.
- Opcode A070 -> error pulse next cycle, cmd_ready stays 1, busy stays 0, filter_command stays 0.
- A010 with pause_req high at strobe 10 for 5 cycles, strobes injected while stopped -> ignored; done only after 64 accepted strobes.
- A040 with abort asserted on the same edge as the 64th strobe -> IDLE, no done, filter_command=0, filter_stop=1.
- rst=0 during a MAIN pass at strobe 20 -> all outputs at reset values; a fresh A020 afterward requires a full 64 strobes.
